// File: rtl/imm_extend_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
package imm_extend_pkg;

  typedef enum logic [1:0] {
    ModeSign   = 2'd0,
    ModeZero   = 2'd1,
    ModeHigh   = 2'd2,
    ModeBranch = 2'd3
  } imm_mode_e;

  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender.
// Build option: IMM_EXTEND_BRANCH_EN enables the BRANCH shifter for mode 3.
module imm_extend_core
  import imm_extend_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] result,
  output logic             err
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] high;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign zext = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign high = {in_imm, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    result = sext;
    err    = 1'b0;
    case (imm_mode_e'(in_mode))
      ModeSign: result = sext;
      ModeZero: result = zext;
      ModeHigh: result = high;
      ModeBranch: begin
`ifdef IMM_EXTEND_BRANCH_EN
        result = {sext[OUT_W-3:0], 2'b00};
`else
        // Unsupported here: fall back to sign extension and flag it.
        result = sext;
        err    = 1'b1;
`endif
      end
      default: begin
        result = sext;
        err    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a 2-entry output FIFO and valid/ready handshakes.
// Build option: IMM_EXTEND_BRANCH_EN (passed through to imm_extend_core).
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_mode_err
);

  logic [OUT_W-1:0] core_result;
  logic             core_err;

  imm_extend_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .in_imm (in_imm),
    .in_mode(in_mode),
    .result (core_result),
    .err    (core_err)
  );

  logic [OUT_W-1:0] data_q [FifoDepth];
  logic             err_q  [FifoDepth];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  // Handshake flags depend on registered count only.
  assign in_ready  = (count_q != 2'(FifoDepth));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data     = data_q[rptr_q];
  assign out_mode_err = err_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = ~wptr_q;
    if (pop)  rptr_d = ~rptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < FifoDepth; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        data_q[wptr_q] <= core_result;
        err_q[wptr_q]  <= core_err;
      end
    end
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; legal range is OUT_W >= IN_W+2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input word offered.
REQ-006 SHALL have port in_ready, output, 1, block can accept an input word this cycle.
REQ-007 SHALL have port in_imm, input, IN_W, raw immediate.
REQ-008 SHALL have port in_mode, input, 2, extension mode: 0 SIGN, 1 ZERO, 2 HIGH, 3 BRANCH.
REQ-009 SHALL have port out_valid, output, 1, extended word available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word.
REQ-011 SHALL have port out_data, output, OUT_W, extended result.
REQ-012 SHALL have port out_mode_err, output, 1, set when the head word was produced from an unsupported mode.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer SHALL occur when out_valid && out_ready.
REQ-014 SIGN SHALL produce in_imm replicated from bit IN_W-1 into bits OUT_W-1..IN_W.
REQ-015 ZERO SHALL produce in_imm with all upper bits 0.
REQ-016 HIGH SHALL produce in_imm shifted left by OUT_W-IN_W, with low bits 0.
REQ-017 BRANCH SHALL produce the sign-extended value shifted left by 2, with low 2 bits 0.
REQ-018 Results SHALL be computed at input time and stored in a 2-entry FIFO holding data plus error bit, with 1-bit read/write pointers and a 0..2 count.
REQ-019 Latency SHALL be one cycle: a word accepted at edge N is presented on out_data with out_valid=1 after edge N.
REQ-020 in_ready SHALL equal (count != 2), taken from registered state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_data and out_mode_err SHALL reflect the head entry and stay stable while out_valid && !out_ready.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Pointers SHALL wrap 1 -> 0 without loss or duplication, so the FIFO delivers words strictly in order.
REQ-024 A push at count==2 SHALL be impossible (in_ready=0), and a pop at count==0 SHALL have no effect.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately clear count, pointers, out_valid=0, out_data=0 and out_mode_err=0, and set in_ready=1 after release, regardless of any in-flight words, which are discarded.
REQ-026 The first transfer after reset SHALL be accepted at the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-027 With macro IMM_EXTEND_BRANCH_EN defined, mode 3 SHALL behave as BRANCH per REQ-017 and out_mode_err SHALL be 0.
REQ-028 Without IMM_EXTEND_BRANCH_EN, mode 3 SHALL produce the SIGN result and set the entry's error bit to 1; no BRANCH shifter SHALL be synthesised.

Structure
REQ-029 A shared package imm_extend_pkg SHALL hold the mode enumeration (SIGN, ZERO, HIGH, BRANCH) and the FIFO depth constant (2).
REQ-030 The extension datapath SHALL be a combinational sub-module imm_extend_core(in_imm, in_mode, result, err); the FIFO and handshake SHALL live in imm_extend_pipe.

Verification
REQ-031 SIGN with 16'hFFE2 (-30) -> out_data 32'hFFFFFFE2 one cycle later; 16'h0028 (40) -> 32'h00000028.
REQ-032 ZERO with 16'hFFE2 -> 32'h0000FFE2; HIGH with 16'h1234 -> 32'h12340000.
REQ-033 BRANCH with 16'hFFFF -> 32'hFFFFFFFC when the macro is defined; 32'hFFFFFFFF with out_mode_err=1 when it is not.
REQ-034 Hold out_ready=0 and push 16'h0001, 16'h0002, 16'h0003 -> in_ready=0 after 2 pushes and the third is held; release out_ready -> outputs 1, 2, 3 in order.
REQ-035 With count==1, push and pop in the same cycle for 20 cycles -> count stays 1 and the sequence is intact across pointer wrap.
REQ-036 Assert rst_n=0 with count==2 -> out_valid=0 and in_ready=1 immediately, and no stale word appears after release.
